// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared opcodes, FSM state type, binary32 field widths and
//               helper functions for the FPU execute path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    localparam int W        = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int SIG_W    = MAN_W + 1;  // significand with hidden bit
    localparam int ALN_W    = SIG_W + 3;  // plus guard, round, sticky
    localparam int SUM_W    = ALN_W + 1;  // plus carry-out

    localparam logic [2:0] FPU_OP_ADD = 3'd0;
    localparam logic [2:0] FPU_OP_SUB = 3'd1;
    localparam logic [2:0] FPU_OP_EQ  = 3'd2;
    localparam logic [2:0] FPU_OP_LT  = 3'd3;
    localparam logic [2:0] FPU_OP_GT  = 3'd4;
    localparam logic [2:0] FPU_OP_LE  = 3'd5;
    localparam logic [2:0] FPU_OP_GE  = 3'd6;
    localparam logic [2:0] FPU_OP_MOV = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } fpu_state_t;

    // Right-shift a significand into the G/R/S field; shifted-out bits fold into sticky.
    function automatic logic [ALN_W-1:0] align_shift(input logic [SIG_W-1:0] sig,
                                                     input logic [EXP_W-1:0] diff);
        logic [ALN_W-1:0] field;
        logic [ALN_W-1:0] shifted;
        logic [ALN_W-1:0] lost_mask;
        field     = {sig, 3'b000};
        shifted   = field >> diff;
        lost_mask = (ALN_W'(1) << diff) - ALN_W'(1);
        if (diff >= EXP_W'(ALN_W)) begin
            return {{(ALN_W-1){1'b0}}, |sig};
        end
        return {shifted[ALN_W-1:1], shifted[0] | (|(field & lost_mask))};
    endfunction

    function automatic logic fpu_eq(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x == y) || ((x[W-2:0] == '0) && (y[W-2:0] == '0));
    endfunction

    function automatic logic fpu_lt(input logic [W-1:0] x, input logic [W-1:0] y);
        if ((x[W-2:0] == '0) && (y[W-2:0] == '0)) begin
            return 1'b0;
        end
        if (x[W-1] != y[W-1]) begin
            return x[W-1];
        end
        if (x[W-1]) begin
            return x[W-2:0] > y[W-2:0];
        end
        return x[W-2:0] < y[W-2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_normalizer.sv
// ============================================================================
// Module      : fpu_normalizer
// Description : Leading-zero count and left shift of the 28-bit sum magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_normalizer
    import fpu_pkg::*;
(
    input  logic [SUM_W-1:0] mag,
    output logic [4:0]       lzc,
    output logic [SUM_W-1:0] shifted
);

    // Last hit wins, so the highest set bit sets the count.
    always_comb begin
        lzc = 5'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (mag[i]) begin
                lzc = 5'(SUM_W - 1 - i);
            end
        end
    end

    assign shifted = mag << lzc;

endmodule

`default_nettype wire

// File: rtl/fpu_exec_unit.sv
// ============================================================================
// Module      : fpu_exec_unit
// Description : Multi-cycle binary32 ADD/SUB/compare/MOV execute unit.
//               Define FPU_EXEC_RNE_EN for round-to-nearest-even, else truncate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_exec_unit
    import fpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op_code,
    input  logic         write_en,
    input  logic         flag_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         reg_we,
    output logic         flag,
    output logic         flag_we
);

`ifdef FPU_EXEC_RNE_EN
    localparam logic c_rne_en = 1'b1;
`else
    localparam logic c_rne_en = 1'b0;
`endif

    fpu_state_t       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_write_en;
    logic             r_flag_en;
    logic [EXP_W-1:0] r_exp;
    logic [ALN_W-1:0] r_fa;
    logic [ALN_W-1:0] r_fb;
    logic             r_sa;
    logic             r_sb;
    logic [SUM_W-1:0] r_sum;
    logic             r_sign;

    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [SIG_W-1:0] w_ma;
    logic [SIG_W-1:0] w_mb;
    logic             w_a_big;
    logic [EXP_W-1:0] w_diff;
    logic [ALN_W-1:0] w_fa;
    logic [ALN_W-1:0] w_fb;
    logic [SUM_W-1:0] w_sum;
    logic             w_sign;
    logic [4:0]       w_lzc;
    logic [SUM_W-1:0] w_norm;
    logic [ALN_W-1:0] w_field;
    logic [SIG_W-1:0] w_sig;
    logic             w_round_up;
    logic [SIG_W:0]   w_sig_r;
    logic [9:0]       w_exp_n;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_add_res;
    logic             w_cmp;

    // ALIGN: unpack, flush denormals, shift the smaller-exponent operand.
    assign w_ea    = r_a[W-2:MAN_W];
    assign w_eb    = r_b[W-2:MAN_W];
    assign w_ma    = (w_ea == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
    assign w_mb    = (w_eb == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
    assign w_a_big = (w_ea >= w_eb);
    assign w_diff  = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_fa    = w_a_big ? {w_ma, 3'b000} : align_shift(w_ma, w_diff);
    assign w_fb    = w_a_big ? align_shift(w_mb, w_diff) : {w_mb, 3'b000};

    always_comb begin
        w_sum  = '0;
        w_sign = r_sa;
        if (r_sa == r_sb) begin
            w_sum  = {1'b0, r_fa} + {1'b0, r_fb};
            w_sign = r_sa;
        end else if (r_fa >= r_fb) begin
            w_sum  = {1'b0, r_fa} - {1'b0, r_fb};
            w_sign = r_sa;
        end else begin
            w_sum  = {1'b0, r_fb} - {1'b0, r_fa};
            w_sign = r_sb;
        end
    end

    fpu_normalizer u_normalizer (
        .mag     (r_sum),
        .lzc     (w_lzc),
        .shifted (w_norm)
    );

    // Leading one lands at bit 27; dropping bit 0 into sticky covers the carry-out case.
    assign w_field    = {w_norm[SUM_W-1:2], w_norm[1] | w_norm[0]};
    assign w_sig      = w_field[ALN_W-1:3];
    assign w_round_up = c_rne_en & w_field[2] & (w_field[1] | w_field[0] | w_sig[0]);
    assign w_sig_r    = {1'b0, w_sig} + {{SIG_W{1'b0}}, w_round_up};
    assign w_exp_n    = {2'b00, r_exp} + 10'd1 + {9'd0, w_sig_r[SIG_W]} - {5'd0, w_lzc};
    assign w_frac     = w_sig_r[SIG_W] ? w_sig_r[SIG_W-1:1] : w_sig_r[MAN_W-1:0];

    always_comb begin
        if (r_sum == '0) begin
            w_add_res = '0;
        end else if ($signed(w_exp_n) >= 10'sd255) begin
            w_add_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ($signed(w_exp_n) <= 10'sd0) begin
            w_add_res = {r_sign, {(W-1){1'b0}}};
        end else begin
            w_add_res = {r_sign, w_exp_n[EXP_W-1:0], w_frac};
        end
    end

    always_comb begin
        case (op_code)
            FPU_OP_EQ: w_cmp = fpu_eq(a, b);
            FPU_OP_LT: w_cmp = fpu_lt(a, b);
            FPU_OP_GT: w_cmp = fpu_lt(b, a);
            FPU_OP_LE: w_cmp = fpu_lt(a, b) | fpu_eq(a, b);
            FPU_OP_GE: w_cmp = ~fpu_lt(a, b);
            default:   w_cmp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            flag         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_write_en   <= 1'b0;
            r_flag_en    <= 1'b0;
            r_exp        <= '0;
            r_fa         <= '0;
            r_fb         <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_sum        <= '0;
            r_sign       <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a        <= a;
                        r_b        <= (op_code == FPU_OP_SUB) ? {~b[W-1], b[W-2:0]} : b;
                        r_write_en <= write_en;
                        r_flag_en  <= flag_en;
                        busy       <= 1'b1;
                        if ((op_code == FPU_OP_ADD) || (op_code == FPU_OP_SUB)) begin
                            r_state <= ST_ALIGN;
                        end else begin
                            r_state      <= ST_DONE;
                            result_valid <= 1'b1;
                            if (op_code == FPU_OP_MOV) begin
                                result <= a;
                            end else begin
                                flag <= w_cmp;
                            end
                        end
                    end
                end
                ST_ALIGN: begin
                    r_exp   <= w_a_big ? w_ea : w_eb;
                    r_fa    <= w_fa;
                    r_fb    <= w_fb;
                    r_sa    <= r_a[W-1];
                    r_sb    <= r_b[W-1];
                    r_state <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum   <= w_sum;
                    r_sign  <= w_sign;
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    result       <= w_add_res;
                    result_valid <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign reg_we  = result_valid & r_write_en;
    assign flag_we = result_valid & r_flag_en;

endmodule

`default_nettype wire

// File: tb/tb_fpu_exec_unit.sv
// ============================================================================
// Module      : tb_fpu_exec_unit
// Description : Directed self-checking bench for fpu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fpu_exec_unit;
    import fpu_pkg::*;

`ifdef FPU_EXEC_RNE_EN
    localparam logic [31:0] c_round_exp = 32'h3F800001;
`else
    localparam logic [31:0] c_round_exp = 32'h3F800000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic        write_en = 1'b0;
    logic        flag_en = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic        reg_we;
    logic        flag;
    logic        flag_we;

    int checks = 0;
    int errors = 0;

    localparam int N_ADD = 8;
    logic [2:0]  add_op  [N_ADD] = '{FPU_OP_ADD, FPU_OP_SUB, FPU_OP_ADD, FPU_OP_SUB,
                                     FPU_OP_ADD, FPU_OP_ADD, FPU_OP_SUB, FPU_OP_ADD};
    logic [31:0] add_a   [N_ADD] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'h3F800000,
                                     32'h7F7FFFFF, 32'h00000001, 32'h80C00000, 32'h3F800000};
    logic [31:0] add_b   [N_ADD] = '{32'h40000000, 32'h3F800000, 32'hBF000000, 32'h40000000,
                                     32'h7F7FFFFF, 32'h3F800000, 32'h80800000, 32'h33C00000};
    logic [31:0] add_exp [N_ADD] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'hBF800000,
                                     32'h7F800000, 32'h3F800000, 32'h80000000, c_round_exp};

    localparam int N_CMP = 6;
    logic [2:0]  cmp_op  [N_CMP] = '{FPU_OP_EQ, FPU_OP_LT, FPU_OP_GE, FPU_OP_GT, FPU_OP_EQ, FPU_OP_LE};
    logic [31:0] cmp_a   [N_CMP] = '{32'h80000000, 32'hBF800000, 32'hBF800000, 32'h40000000,
                                     32'h3F800000, 32'hC0000000};
    logic [31:0] cmp_b   [N_CMP] = '{32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                                     32'h40000000, 32'hBF800000};
    logic        cmp_exp [N_CMP] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    fpu_exec_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_code      (op_code),
        .write_en     (write_en),
        .flag_en      (flag_en),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .reg_we       (reg_we),
        .flag         (flag),
        .flag_we      (flag_we)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of the cycle after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic we, input logic fe);
        start = 1'b1; op_code = op; a = ia; b = ib; write_en = we; flag_en = fe;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
        checks++; if ({result_valid, reg_we, flag_we} !== 3'b000) begin
            errors++; $display("FAIL reset_valid got %b want 000", {result_valid, reg_we, flag_we});
        end
        checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", flag); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        int lat;
        for (int i = 0; i < N_ADD; i++) begin
            issue(add_op[i], add_a[i], add_b[i], 1'b1, 1'b0);
            wait_valid(lat);
            checks++; if (lat != 4) begin errors++; $display("FAIL add_latency[%0d] got %0d want 4", i, lat); end
            checks++; if (result !== add_exp[i]) begin
                errors++; $display("FAIL add_result[%0d] got %h want %h", i, result, add_exp[i]);
            end
            checks++; if ({reg_we, flag_we, busy} !== 3'b101) begin
                errors++; $display("FAIL add_we[%0d] got %b want 101", i, {reg_we, flag_we, busy});
            end
            @(negedge clk);
            checks++; if ({result_valid, busy} !== 2'b00) begin
                errors++; $display("FAIL add_pulse[%0d] got %b want 00", i, {result_valid, busy});
            end
        end
    endtask

    task automatic test_compare();
        int lat;
        for (int i = 0; i < N_CMP; i++) begin
            issue(cmp_op[i], cmp_a[i], cmp_b[i], 1'b0, 1'b1);
            wait_valid(lat);
            checks++; if (lat != 1) begin errors++; $display("FAIL cmp_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (flag !== cmp_exp[i]) begin
                errors++; $display("FAIL cmp_flag[%0d] got %b want %b", i, flag, cmp_exp[i]);
            end
            checks++; if ({flag_we, reg_we} !== 2'b10) begin
                errors++; $display("FAIL cmp_we[%0d] got %b want 10", i, {flag_we, reg_we});
            end
            checks++; if (result !== add_exp[N_ADD-1]) begin
                errors++; $display("FAIL cmp_result_hold[%0d] got %h want %h", i, result, add_exp[N_ADD-1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mov();
        int lat;
        issue(FPU_OP_MOV, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b0);
        wait_valid(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL mov_latency got %0d want 1", lat); end
        checks++; if (result !== 32'h12345678) begin errors++; $display("FAIL mov_result got %h want 12345678", result); end
        checks++; if ({reg_we, flag_we, flag} !== 3'b101) begin
            errors++; $display("FAIL mov_we_flag got %b want 101", {reg_we, flag_we, flag});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        issue(FPU_OP_GT, 32'h40000000, 32'h3F800000, 1'b0, 1'b1);
        checks++; if ({result_valid, flag} !== 2'b11) begin
            errors++; $display("FAIL b2b_first got %b want 11", {result_valid, flag});
        end
        start = 1'b1; op_code = FPU_OP_MOV; a = 32'hCAFEF00D; write_en = 1'b1; flag_en = 1'b0;
        @(negedge clk);
        checks++; if ({busy, result_valid} !== 2'b00) begin
            errors++; $display("FAIL b2b_done_ignore got %b want 00", {busy, result_valid});
        end
        @(negedge clk);
        start = 1'b0;
        checks++; if ({result_valid, reg_we} !== 2'b11 || result !== 32'hCAFEF00D) begin
            errors++; $display("FAIL b2b_second got valid/we %b result %h want 11 cafef00d", {result_valid, reg_we}, result);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat;
        logic seen;
        issue(FPU_OP_ADD, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
        seen = result_valid;
        @(negedge clk);
        seen |= result_valid;
        start = 1'b1; op_code = FPU_OP_MOV; a = 32'hDEADBEEF;
        @(negedge clk);
        seen |= result_valid;
        start = 1'b0; rst = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_c3 got %b want 1", busy); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_c4 got %b want 0", busy); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL abort_result got %h want 00000000", result); end
        repeat (5) begin
            seen |= result_valid;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid got %b want 0", seen); end
        issue(FPU_OP_ADD, 32'h40000000, 32'h40000000, 1'b1, 1'b0);
        wait_valid(lat);
        checks++; if (lat != 4 || result !== 32'h40800000) begin
            errors++; $display("FAIL abort_recover got lat %0d result %h want 4 40800000", lat, result);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op_code = FPU_OP_ADD;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got %b want 0", busy); end
        repeat (5) begin
            seen |= result_valid;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_start_no_valid got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare();
        test_mov();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
